// File: rtl/pixart_i2c_target_if.sv
// Bus-side bundle for the Pixart camera emulator: open-drain SDA pins,
// the blob position feeding the report window, and the register-write tap.
interface pixart_i2c_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_out;
   logic       sda_dir;
   logic [9:0] blob_x;
   logic [9:0] blob_y;
   logic [3:0] blob_size;
   logic       blob_valid;
   logic       wr_strobe;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, blob_x, blob_y, blob_size, blob_valid,
      output sda_out, sda_dir, wr_strobe, wr_addr, wr_data, busy
   );

   modport master (
      output scl_in, sda_in, blob_x, blob_y, blob_size, blob_valid,
      input  sda_out, sda_dir, wr_strobe, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/pixart_i2c_target.sv
// Oversampling I2C target emulating the Pixart IR camera: 64-byte config
// register file plus a 16-byte blob report window snapshotted per read.
module pixart_i2c_target #(
   parameter logic [6:0] ADDR        = 7'h58,
   parameter logic [7:0] REPORT_BASE = 8'h36
) (
   input logic clk,
   input logic reset,
   pixart_i2c_target_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
   } state_t;

   logic scl_s1_q, scl_s2_q, scl_h_q;
   logic sda_s1_q, sda_s2_q, sda_h_q;

   state_t      state_q, state_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  shr_q, shr_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        rw_q, rw_d;
   logic [23:0] snap_q, snap_d;
   logic [7:0]  regfile_q [64];
   logic [7:0]  regfile_d [64];
   logic        sda_dir_q, sda_dir_d;
   logic        busy_q, busy_d;
   logic        wr_strobe_q, wr_strobe_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;

   logic        scl_rise, scl_fall, start, stop;
   logic [7:0]  rd_off, rd_byte;
   logic [23:0] snap_src;

   assign scl_rise = scl_s2_q & ~scl_h_q;
   assign scl_fall = ~scl_s2_q & scl_h_q;
   assign start    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
   assign stop     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

   assign snap_src = bus.blob_valid
      ? {bus.blob_y[9:8], bus.blob_x[9:8], bus.blob_size,
         bus.blob_y[7:0], bus.blob_x[7:0]}
      : 24'hFF_FFFF;

   // Offset wraps below REPORT_BASE, so one compare selects the window.
   always_comb begin
      rd_off  = ptr_q - REPORT_BASE;
      rd_byte = 8'h00;
      if (rd_off < 8'd16) begin
         case (rd_off[3:0])
            4'd0:    rd_byte = 8'h00;
            4'd1:    rd_byte = snap_q[7:0];
            4'd2:    rd_byte = snap_q[15:8];
            4'd3:    rd_byte = snap_q[23:16];
            default: rd_byte = 8'hFF;
         endcase
      end else if (ptr_q < 8'h40) begin
         rd_byte = regfile_q[ptr_q[5:0]];
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      shr_d       = shr_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      snap_d      = snap_q;
      regfile_d   = regfile_q;
      sda_dir_d   = sda_dir_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;

      if (start) begin
         state_d   = S_ADDR;
         bit_d     = 4'd0;
         sda_dir_d = 1'b0;
      end else if (stop) begin
         state_d   = S_IDLE;
         sda_dir_d = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_REG, S_WDATA: begin
               if (scl_rise) begin
                  shr_d = {shr_q[6:0], sda_s2_q};
                  bit_d = bit_q + 4'd1;
               end else if (scl_fall && bit_q == 4'd8) begin
                  bit_d     = 4'd0;
                  sda_dir_d = 1'b1;
                  if (state_q == S_REG) begin
                     ptr_d   = shr_q;
                     state_d = S_REG_ACK;
                  end else if (state_q == S_WDATA) begin
                     if (ptr_q < 8'h40)
                        regfile_d[ptr_q[5:0]] = shr_q;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = ptr_q;
                     wr_data_d   = shr_q;
                     ptr_d       = ptr_q + 8'd1;
                     state_d     = S_WDATA_ACK;
                  end else if (shr_q[7:1] == ADDR) begin
                     busy_d  = 1'b1;
                     rw_d    = shr_q[0];
                     snap_d  = snap_src;
                     state_d = S_ADDR_ACK;
                  end else begin
                     sda_dir_d = 1'b0;
                     state_d   = S_IGNORE;
                  end
               end
            end
            S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
               if (scl_fall) begin
                  bit_d     = 4'd0;
                  sda_dir_d = 1'b0;
                  if (state_q != S_ADDR_ACK) begin
                     state_d = S_WDATA;
                  end else if (rw_q) begin
                     sda_dir_d = ~rd_byte[7];
                     bit_d     = 4'd1;
                     state_d   = S_RDATA;
                  end else begin
                     state_d = S_REG;
                  end
               end
            end
            S_RDATA: begin
               if (scl_fall) begin
                  if (bit_q == 4'd8) begin
                     sda_dir_d = 1'b0;
                     state_d   = S_RACK;
                  end else begin
                     sda_dir_d = ~rd_byte[~bit_q[2:0]];
                     bit_d     = bit_q + 4'd1;
                  end
               end
            end
            S_RACK: begin
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     ptr_d   = ptr_q + 8'd1;
                     bit_d   = 4'd0;
                     state_d = S_RDATA;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_h_q     <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_h_q     <= 1'b1;
         state_q     <= S_IDLE;
         bit_q       <= 4'd0;
         shr_q       <= 8'h00;
         ptr_q       <= 8'h00;
         rw_q        <= 1'b0;
         snap_q      <= 24'h0;
         for (int i = 0; i < 64; i++)
            regfile_q[i] <= 8'h00;
         sda_dir_q   <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 8'h00;
         wr_data_q   <= 8'h00;
      end else begin
         scl_s1_q    <= bus.scl_in;
         scl_s2_q    <= scl_s1_q;
         scl_h_q     <= scl_s2_q;
         sda_s1_q    <= bus.sda_in;
         sda_s2_q    <= sda_s1_q;
         sda_h_q     <= sda_s2_q;
         state_q     <= state_d;
         bit_q       <= bit_d;
         shr_q       <= shr_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         snap_q      <= snap_d;
         regfile_q   <= regfile_d;
         sda_dir_q   <= sda_dir_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign bus.sda_out   = 1'b0;
   assign bus.sda_dir   = sda_dir_q;
   assign bus.busy      = busy_q;
   assign bus.wr_strobe = wr_strobe_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_pixart_i2c_target.sv
// Directed bench: bit-banged I2C initiator with open-drain SDA and
// scoreboards for read bytes and register-write strobes.
module tb_pixart_i2c_target;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   pixart_i2c_target_if bus ();

   pixart_i2c_target dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_dir;

   int n_cmp = 0;
   int n_bad = 0;
   int dir_cnt = 0;
   int wr_idx = 0;
   logic [15:0] obs_wr [$];
   logic [15:0] exp_wr [$];
   logic [7:0]  exp_q  [$];

   always @(negedge clk) begin
      if (bus.sda_dir) dir_cnt <= dir_cnt + 1;
      if (bus.wr_strobe) obs_wr.push_back({bus.wr_addr, bus.wr_data});
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (8) @(posedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 0; i < 8; i++) begin
         sda_m = b[7-i]; wait_q();
         scl_m = 1'b1; wait_q(); wait_q();
         scl_m = 1'b0; wait_q();
      end
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      ack = bus.sda_in; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic send_chk(input string tag, input logic [7:0] b,
                           input logic exp_ack);
      logic a;
      send_byte(b, a);
      chk(tag, {31'd0, a}, {31'd0, exp_ack});
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b = bus.sda_in; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic rd_chk(input string tag, input logic ack);
      logic [7:0] d;
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         d = {d[6:0], b};
      end
      sda_m = ~ack; wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
      sda_m = 1'b1;
      chk(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
   endtask

   task automatic check_wr(input string tag);
      logic [31:0] o;
      logic [15:0] e;
      chk({tag, "_n"}, obs_wr.size(), wr_idx + exp_wr.size());
      while (exp_wr.size() > 0) begin
         e = exp_wr.pop_front();
         o = (wr_idx < obs_wr.size()) ? {16'd0, obs_wr[wr_idx]} : 'x;
         wr_idx++;
         chk(tag, o, {16'd0, e});
      end
      wr_idx = obs_wr.size();
   endtask

   task automatic set_ptr_read(input logic [7:0] p);
      i2c_start();
      send_chk("adw", 8'hB0, 1'b0);
      send_chk("reg", p, 1'b0);
      i2c_start();
      send_chk("adr", 8'hB1, 1'b0);
   endtask

   initial begin
      logic b;
      int d0;
      bus.blob_x = 10'd0;
      bus.blob_y = 10'd0;
      bus.blob_size = 4'd0;
      bus.blob_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_dir", {31'd0, bus.sda_dir}, 32'd0);
      chk("rst_out", {31'd0, bus.sda_out}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_stb", {31'd0, bus.wr_strobe}, 32'd0);
      chk("rst_wa", {24'd0, bus.wr_addr}, 32'd0);
      chk("rst_wd", {24'd0, bus.wr_data}, 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (4) @(posedge clk);

      // plain write of two bytes
      i2c_start();
      send_chk("w1_adr", 8'hB0, 1'b0);
      send_chk("w1_reg", 8'h30, 1'b0);
      exp_wr.push_back(16'h30A5);
      send_chk("w1_d0", 8'hA5, 1'b0);
      exp_wr.push_back(16'h315A);
      send_chk("w1_d1", 8'h5A, 1'b0);
      chk("w1_busy", {31'd0, bus.busy}, 32'd1);
      i2c_stop();
      wait_q();
      chk("w1_idle", {31'd0, bus.busy}, 32'd0);
      check_wr("w1_wr");

      // foreign address is never acknowledged
      d0 = dir_cnt;
      i2c_start();
      send_chk("na_adr", 8'h42, 1'b1);
      send_chk("na_dat", 8'h30, 1'b1);
      chk("na_busy", {31'd0, bus.busy}, 32'd0);
      i2c_stop();
      wait_q();
      chk("na_dir", dir_cnt, d0);
      check_wr("na_wr");

      // blob report, snapshot held while blob_x moves
      bus.blob_x = 10'h2AB;
      bus.blob_y = 10'h1CD;
      bus.blob_size = 4'd5;
      bus.blob_valid = 1'b1;
      set_ptr_read(8'h36);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hAB);
      exp_q.push_back(8'hCD);
      exp_q.push_back(8'h65);
      rd_chk("rp0", 1'b1);
      bus.blob_x = 10'h3FF;
      rd_chk("rp1", 1'b1);
      rd_chk("rp2", 1'b1);
      rd_chk("rp3", 1'b0);
      i2c_stop();

      // regfile readback
      set_ptr_read(8'h30);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      rd_chk("rb0", 1'b1);
      rd_chk("rb1", 1'b0);
      i2c_stop();

      // no blob: 00 then fifteen FF
      bus.blob_valid = 1'b0;
      bus.blob_x = 10'h2AB;
      set_ptr_read(8'h36);
      exp_q.push_back(8'h00);
      repeat (15) exp_q.push_back(8'hFF);
      for (int i = 0; i < 16; i++) begin
         if (i == 2) bus.blob_x = 10'h001;
         rd_chk($sformatf("nv%0d", i), i != 15);
      end
      i2c_stop();

      // pointer wrap on write
      i2c_start();
      send_chk("wr_adr", 8'hB0, 1'b0);
      send_chk("wr_reg", 8'hFF, 1'b0);
      exp_wr.push_back(16'hFF11);
      send_chk("wr_d0", 8'h11, 1'b0);
      exp_wr.push_back(16'h0022);
      send_chk("wr_d1", 8'h22, 1'b0);
      i2c_stop();
      check_wr("wrap_wr");
      set_ptr_read(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h22);
      rd_chk("wrap_ff", 1'b1);
      rd_chk("wrap_00", 1'b0);
      i2c_stop();
      set_ptr_read(8'h30);
      exp_q.push_back(8'hA5);
      rd_chk("wrap_30", 1'b0);
      i2c_stop();

      // reset during 5th bit of a read (A5 bit3 = 0, so SDA is held low)
      set_ptr_read(8'h30);
      for (int i = 0; i < 4; i++) read_bit(b);
      sda_m = 1'b1; wait_q();
      chk("mr_pre", {31'd0, bus.sda_dir}, 32'd1);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_dir", {31'd0, bus.sda_dir}, 32'd0);
      @(negedge clk) reset = 1'b0;
      wait_q();
      i2c_stop();
      wr_idx = obs_wr.size();
      i2c_start();
      send_chk("pr_adr", 8'hB0, 1'b0);
      send_chk("pr_reg", 8'h05, 1'b0);
      exp_wr.push_back(16'h0577);
      send_chk("pr_d0", 8'h77, 1'b0);
      i2c_stop();
      wait_q();
      chk("pr_busy", {31'd0, bus.busy}, 32'd0);
      check_wr("pr_wr");
      set_ptr_read(8'h05);
      exp_q.push_back(8'h77);
      rd_chk("pr_05", 1'b0);
      i2c_stop();
      set_ptr_read(8'h30);
      exp_q.push_back(8'h00);
      rd_chk("pr_30", 1'b0);
      i2c_stop();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
